// File: rtl/prog_seq_launcher_if.sv
// Handshake and record-readout bundle between a run controller and its host/core side.
// The host side (go, halt, rd_idx) is the master; the launcher is the slave.
interface prog_seq_launcher_if #(
    parameter int NUM_PROGS = 3,
    parameter int CYC_W     = 16,
    parameter int ID_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
);
    logic                 go;
    logic                 halt;
    logic                 start;
    logic [ID_W-1:0]      prog_id;
    logic                 busy;
    logic                 done;
    logic [NUM_PROGS-1:0] timeout_err;
    logic [ID_W-1:0]      rd_idx;
    logic [CYC_W-1:0]     rd_cycles;

    modport master (
        output go, halt, rd_idx,
        input  start, prog_id, busy, done, timeout_err, rd_cycles
    );

    modport slave (
        input  go, halt, rd_idx,
        output start, prog_id, busy, done, timeout_err, rd_cycles
    );
endinterface

// File: rtl/prog_seq_launcher.sv
// Run controller: launches NUM_PROGS programs back to back on the core via start/halt,
// records each program's run length in cycles and flags programs that time out.
module prog_seq_launcher #(
    parameter int NUM_PROGS    = 3,
    parameter int START_CYCLES = 1,
    parameter int CYC_W        = 16,
    parameter int TIMEOUT      = 0,
    parameter int ID_W         = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input logic               clk,
    input logic               rst_n,
    prog_seq_launcher_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int              LC_W        = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [LC_W-1:0] LAUNCH_LAST = LC_W'(START_CYCLES - 1);
    localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NUM_PROGS - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_V  = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] CNT_MAX    = '1;

    state_t               state_q, state_d;
    logic [CYC_W-1:0]     cnt_q, cnt_d;
    logic [LC_W-1:0]      lcnt_q, lcnt_d;
    logic [ID_W-1:0]      prog_id_q, prog_id_d;
    logic                 halt_q, halt_d;
    logic [CYC_W-1:0]     rec_q [NUM_PROGS];
    logic [CYC_W-1:0]     rec_d [NUM_PROGS];
    logic [NUM_PROGS-1:0] timeout_err_q, timeout_err_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic halt_rise;
    logic timeout_hit;
    logic launch_last;
    logic prog_last;

    // A halt that is already high when RUN begins is not a completion; only a fresh rise counts.
    assign halt_rise   = bus.halt & ~halt_q;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT_V) && !halt_rise;
    assign launch_last = (lcnt_q == LAUNCH_LAST);
    assign prog_last   = (prog_id_q == LAST_ID);
    assign halt_d      = bus.halt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            lcnt_q        <= '0;
            prog_id_q     <= '0;
            halt_q        <= 1'b0;
            timeout_err_q <= '0;
            start_q       <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            for (int i = 0; i < NUM_PROGS; i++) begin
                rec_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lcnt_q        <= lcnt_d;
            prog_id_q     <= prog_id_d;
            halt_q        <= halt_d;
            timeout_err_q <= timeout_err_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            for (int i = 0; i < NUM_PROGS; i++) begin
                rec_q[i] <= rec_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (bus.go) state_d = S_LAUNCH;
            S_LAUNCH:       if (launch_last) state_d = S_RUN;
            S_RUN:          if (halt_rise || timeout_hit) state_d = S_NEXT;
            S_NEXT:         state_d = prog_last ? S_DONE : S_LAUNCH;
            default:        state_d = S_IDLE;
        endcase
    end

    // Counters and records; completion takes priority over a timeout landing in the same cycle.
    always_comb begin
        cnt_d         = cnt_q;
        lcnt_d        = lcnt_q;
        prog_id_d     = prog_id_q;
        timeout_err_d = timeout_err_q;
        for (int i = 0; i < NUM_PROGS; i++) begin
            rec_d[i] = rec_q[i];
        end
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.go) begin
                    prog_id_d     = '0;
                    lcnt_d        = '0;
                    timeout_err_d = '0;
                    for (int i = 0; i < NUM_PROGS; i++) begin
                        rec_d[i] = '0;
                    end
                end
            end
            S_LAUNCH: begin
                if (launch_last) begin
                    cnt_d = CYC_W'(1);
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (halt_rise) begin
                    rec_d[prog_id_q] = cnt_q;
                end else if (timeout_hit) begin
                    rec_d[prog_id_q]         = TIMEOUT_V;
                    timeout_err_d[prog_id_q] = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_NEXT: begin
                lcnt_d = '0;
                if (!prog_last) begin
                    prog_id_d = prog_id_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        start_d = (state_d != S_RUN);
        busy_d  = (state_d == S_LAUNCH) || (state_d == S_RUN) || (state_d == S_NEXT);
        done_d  = (state_d == S_DONE);
    end

    always_comb begin
        bus.rd_cycles = '0;
        if (int'(bus.rd_idx) < NUM_PROGS) begin
            bus.rd_cycles = rec_q[bus.rd_idx];
        end
    end

    assign bus.start       = start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.prog_id     = prog_id_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/prog_seq_launcher.md
# prog_seq_launcher

Synthesizable, parametrised run controller for the core's `start`/`halt` handshake. It sequences NUM_PROGS back-to-back program launches on the core and records the run length of each program in clock cycles. It flags any program that fails to halt within a timeout. It sits between a host or self-test `go` source and the TopLevel core, replacing hand-timed `start` pulsing with a hardware state machine.

## Interface
Parameters:
- NUM_PROGS, 3: number of programs launched per sequence (≥1)
- START_CYCLES, 1: cycles `start` is held high per launch (≥1)
- CYC_W, 16: width of each cycle-count record
- TIMEOUT, 0: RUN-cycle limit per program; 0 disables the timeout
- ID_W, max(1, clog2(NUM_PROGS)): width of prog_id and rd_idx

Ports:
- CLK  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- go  in  1  sequence request, sampled in IDLE/DONE
- halt  in  1  core done flag
- start  out  1  core start/reset; core runs while low
- prog_id  out  ID_W  index of the current/last program
- busy  out  1  high in LAUNCH/RUN/NEXT
- done  out  1  high in DONE
- timeout_err  out  NUM_PROGS  sticky per-program timeout flags
- rd_idx  in  ID_W  record select
- rd_cycles  out  CYC_W  cycle record[rd_idx], combinational read

## Operation
- States: IDLE, LAUNCH, RUN, NEXT, DONE. All outputs are registered except rd_cycles.
- IDLE: start=1, busy=0. On go=1, clear all records and timeout_err, set prog_id=0, and enter LAUNCH.
- LAUNCH: start=1 for exactly START_CYCLES cycles, then enter RUN. halt is ignored.
- RUN: start=0 and cnt increments each cycle. Completion is a rising edge of halt (halt=1 with halt_q=0, where halt_q is halt registered every cycle in all states). On completion, record[prog_id]=cnt and enter NEXT.
- Timeout: TIMEOUT≠0 and cnt==TIMEOUT with no completion in that cycle. Then record[prog_id]=TIMEOUT, set timeout_err[prog_id], and enter NEXT.
- Simultaneous completion and timeout in the same cycle: completion wins and no error is flagged.
- cnt saturates at 2^CYC_W−1 and does not wrap. If TIMEOUT=0 and halt never rises, the block stays in RUN until reset.
- NEXT: one cycle with start=1. If prog_id==NUM_PROGS−1, enter DONE. Otherwise increment prog_id and enter LAUNCH.
- DONE: start=1, done=1, records held. go=1 restarts exactly as from IDLE; done drops on the next cycle.
- go while busy is ignored.
- rd_idx ≥ NUM_PROGS returns rd_cycles=0.

## Timing
- Reset (rst_n=0 at a rising edge) forces, at that edge:
  - state=IDLE, start=1, prog_id=0, busy=0, done=0
  - timeout_err=0, all records=0, cnt=0, halt_q=0
- Reset has priority over every event, including mid-RUN. A run in progress is abandoned and no record is written.
- go sampled at edge t: LAUNCH begins at t+1 (start stays 1, busy=1).
- start falls on the edge after START_CYCLES LAUNCH cycles. The first RUN cycle has cnt=1.
- If the halt rising edge is sampled in the k-th RUN cycle, record=k. start rises on the following edge (NEXT).
- Consecutive programs have a gap of exactly 1 + START_CYCLES cycles with start=1.
- halt already high on entering RUN is not a completion. It must fall and rise again.
- Records update on the NEXT-entry edge. rd_cycles reflects them in the same cycle they are written.

## Test plan
Configuration for all scenarios: NUM_PROGS=3, START_CYCLES=2, TIMEOUT=100.
- Reset: rst_n=0 for 2 cycles -> start=1, busy=0, done=0, timeout_err=3'b000, rd_cycles=0 for rd_idx 0..3.
- Nominal: go pulse; core model raises halt 10 cycles after each start fall -> prog_id steps 0,1,2; records 10,10,10; start high for exactly 3 cycles between runs; done=1, timeout_err=3'b000.
- Timeout: program 1 never halts -> record[1]=100, timeout_err=3'b010, program 2 still runs (record 10), done=1.
- Stale halt: halt high through LAUNCH and the first RUN cycle, low in cycles 2–4, rising in cycle 5 -> record=5, no early completion.
- Reset mid-run: rst_n=0 during program 1 RUN -> next edge IDLE, start=1, records cleared. A new go restarts at prog_id=0.
- Re-go and ignore: go pulses during RUN have no effect. go in DONE drops done, clears records/flags, and the rerun produces identical records.
